exp_adder_arbiter: RTL and testbench
====================================

# exp_adder_arbiter

Round-robin arbiter and sequencer that shares one `exp_adder` instance between `N_REQ` posit-multiply requesters. It accepts an operand set from one requester at a time and drives the adder's `start` / `done` / `valid_out` handshake. It returns the adder's exponent, sign and flags to the winning requester, tagged with that requester's index.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2; `ID_W = $clog2(N_REQ)` (localparam)
- `ES`, 3: exponent field width
- `K_BITS`, 6: regime width
- `MAX_BITS`, `ES+K_BITS`: raw exponent width
- `TIMEOUT_CYC`, 15: watchdog limit in cycles, used only under the macro

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `req` in `N_REQ`: per-requester request level, held until granted
- `req_exp_A`, `req_exp_B` in `N_REQ*ES`: operand exponents; requester i uses slice `[i*ES +: ES]`
- `req_k_A`, `req_k_B` in `N_REQ*K_BITS`: operand regimes, sliced the same way
- `req_sign_A`, `req_sign_B` in `N_REQ`: operand signs
- `gnt` out `N_REQ`: one-hot, one-cycle accept pulse
- `adder_start` out 1: start pulse to the adder
- `adder_exp_A`, `adder_exp_B` out `ES`; `adder_k_A`, `adder_k_B` out `K_BITS`; `adder_sign_A`, `adder_sign_B` out 1: latched operands
- `adder_valid_out` out 1: result-consumed pulse to the adder
- `adder_done`, `adder_sign`, `adder_NaR`, `adder_zero` in 1; `adder_exp_raw` in `MAX_BITS`: adder results
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake
- `rsp_id` out `ID_W`; `rsp_exp_raw` out `MAX_BITS`; `rsp_sign`, `rsp_NaR`, `rsp_zero`, `rsp_err` out 1: response payload
- `busy` out 1: high in every state except IDLE

## Operation
- FSM states: IDLE → ISSUE → WAIT → SETTLE → RESP → DRAIN → IDLE. All outputs are registered.
- **IDLE**
  - If `req != 0`, pick the first set bit searching upward from `ptr+1`, wrapping modulo `N_REQ`.
  - Latch that requester's operands onto the `adder_*` operand outputs.
  - Set `gnt[i]`, set `ptr<=i`, go to ISSUE.
- **ISSUE** (one cycle): `adder_start=1` and `gnt` high. Go to WAIT. Operands stay stable until the next grant.
- **WAIT**: when `adder_done` is seen high, go to SETTLE. The adder's flags are valid one cycle after `done` rises.
- **SETTLE** (one cycle)
  - Capture `adder_exp_raw`, `adder_sign`, `adder_NaR`, `adder_zero` into `rsp_*`, with `rsp_id<=ptr` and `rsp_err<=0`.
  - Set `rsp_valid<=1` and go to RESP.
- **RESP**: hold the payload. On `rsp_valid && rsp_ready`: `rsp_valid<=0`, `adder_valid_out<=1`, go to DRAIN.
- **DRAIN** (one cycle): `adder_valid_out=1`, then go to IDLE. The extra IDLE cycle lets the adder's stale `done` clear before the next ISSUE.
- Requests arriving outside IDLE wait. A requester that drops `req` before its grant is skipped without error.
- Reset values:
  - All outputs 0; `ptr=N_REQ-1`, so requester 0 has first priority; state IDLE.
  - Reset during any state aborts the operation with no response. The adder is reset from the same `rst_n`.

## Timing
- Cycle S = ISSUE. The adder sees `start` at the edge ending S and `done` is visible in cycle S+4.
- SETTLE is S+5 and `rsp_valid` rises in S+6: response latency is 6 cycles after `gnt`.
- With `rsp_ready=1`, the next ISSUE is at S+9: the throughput is 1 operation per 9 cycles.
- `rsp_ready` low stalls in RESP indefinitely. The payload stays stable and `adder_valid_out` stays 0.
- `gnt` and `adder_start` are asserted in the same cycle, exactly once per operation.

## Configuration
- **`EXP_ARB_WATCHDOG_EN` defined**
  - A `$clog2(TIMEOUT_CYC+1)`-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYC` with `adder_done` still low, go to RESP with `rsp_NaR=1`, `rsp_err=1`, `rsp_exp_raw=0`, `rsp_sign=0`, `rsp_zero=0`, `rsp_id=ptr`.
  - After the handshake, return straight to IDLE, skipping DRAIN and with no `adder_valid_out` pulse.
- **Macro undefined**: no counter exists, WAIT is unbounded, and `rsp_err` is tied 0.

## Test plan
- **Single request**: `req=4'b0010`, k_A=2, exp_A=3, k_B=1, exp_B=5, sign_A=1, sign_B=0 → `gnt=0010` for one cycle, `rsp_valid` 6 cycles later, `rsp_id=1`, `rsp_exp_raw=32`, `rsp_sign=1`, `rsp_err=0`.
- **All requesters at once**: `req=4'b1111` held, `rsp_ready=1` → grants in order 0,1,2,3,0; ISSUE-to-ISSUE spacing is 9 cycles; exactly one `adder_valid_out` pulse per response.
- **Backpressure**: `rsp_ready=0` for 5 cycles in RESP → payload stable, no `adder_valid_out`, no new `gnt`; then raise `rsp_ready` → DRAIN, then IDLE.
- **Reset mid-operation**: assert `rst_n` low in WAIT → all outputs 0 immediately; after release, `req=4'b1000` → `rsp_id=3`, correct sum.
- **Flag passthrough**: adder model drives `adder_NaR=1` one cycle after `done` → `rsp_NaR=1`, `rsp_zero=0`.
- **Watchdog** (macro on, `TIMEOUT_CYC=15`): adder model never raises `done` → response 15 cycles after entering WAIT with `rsp_NaR=1`, `rsp_err=1`; with the macro off, `busy` stays high.

Source files
------------

// File: rtl/exp_adder_arbiter.sv
// exp_adder_arbiter: round-robin arbiter/sequencer sharing one exp_adder among N_REQ requesters
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req                             per-requester request level, held until granted
//   req_exp_A/B, req_k_A/B          packed operand exponents/regimes, requester i at [i*W +: W]
//   req_sign_A/B                    operand signs
//   gnt                             one-hot accept pulse, coincident with adder_start
//   adder_start                     start pulse to the adder
//   adder_exp_A/B, adder_k_A/B,
//   adder_sign_A/B                  operands latched at grant, stable until the next grant
//   adder_valid_out                 result-consumed pulse to the adder
//   adder_done, adder_exp_raw,
//   adder_sign, adder_NaR,
//   adder_zero                      adder results; flags valid one cycle after done
//   rsp_valid/rsp_ready             response handshake
//   rsp_id, rsp_exp_raw, rsp_sign,
//   rsp_NaR, rsp_zero, rsp_err      response payload tagged with the winning requester
//   busy                            high in every state except IDLE
//
// Optional feature: define EXP_ARB_WATCHDOG_EN to bound the wait for adder_done by
// TIMEOUT_CYC cycles and return an error response (rsp_NaR=1, rsp_err=1) on expiry.
module exp_adder_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ES          = 3,
    parameter int K_BITS      = 6,
    parameter int MAX_BITS    = ES + K_BITS,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ES-1:0]        req_exp_A,
    input  logic [N_REQ*ES-1:0]        req_exp_B,
    input  logic [N_REQ*K_BITS-1:0]    req_k_A,
    input  logic [N_REQ*K_BITS-1:0]    req_k_B,
    input  logic [N_REQ-1:0]           req_sign_A,
    input  logic [N_REQ-1:0]           req_sign_B,
    output logic [N_REQ-1:0]           gnt,
    output logic                       adder_start,
    output logic [ES-1:0]              adder_exp_A,
    output logic [ES-1:0]              adder_exp_B,
    output logic [K_BITS-1:0]          adder_k_A,
    output logic [K_BITS-1:0]          adder_k_B,
    output logic                       adder_sign_A,
    output logic                       adder_sign_B,
    output logic                       adder_valid_out,
    input  logic                       adder_done,
    input  logic                       adder_sign,
    input  logic                       adder_NaR,
    input  logic                       adder_zero,
    input  logic [MAX_BITS-1:0]        adder_exp_raw,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [MAX_BITS-1:0]        rsp_exp_raw,
    output logic                       rsp_sign,
    output logic                       rsp_NaR,
    output logic                       rsp_zero,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SETTLE, RESP, DRAIN} state_t;

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [N_REQ-1:0]    gnt_q;
    logic                start_q;
    logic                valid_out_q;
    logic                busy_q;
    logic [ES-1:0]       exp_a_q, exp_b_q;
    logic [K_BITS-1:0]   k_a_q, k_b_q;
    logic                sign_a_q, sign_b_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [MAX_BITS-1:0] rsp_exp_q;
    logic                rsp_sign_q, rsp_nar_q, rsp_zero_q;

    logic [ID_W-1:0]     pick_d;
    logic                found_d;
    logic [ID_W-1:0]     idx;
    logic [ES-1:0]       exp_a_d, exp_b_d;
    logic [K_BITS-1:0]   k_a_d, k_b_d;
    logic                sign_a_d, sign_b_d;

`ifdef EXP_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_q;
    logic                rsp_err_q;
`endif

    // Round-robin pick: scanning from the farthest candidate back to ptr+1 lets the
    // nearest requester after ptr overwrite the others, giving first-set-bit-from-ptr+1.
    always_comb begin
        pick_d   = ptr_q;
        found_d  = 1'b0;
        idx      = '0;
        for (int j = N_REQ; j >= 1; j--) begin
            idx = ID_W'((int'(ptr_q) + j) % N_REQ);
            if (req[idx]) begin
                pick_d  = idx;
                found_d = 1'b1;
            end
        end
        exp_a_d  = '0;
        exp_b_d  = '0;
        k_a_d    = '0;
        k_b_d    = '0;
        sign_a_d = 1'b0;
        sign_b_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_d == ID_W'(i)) begin
                exp_a_d  = req_exp_A[i*ES +: ES];
                exp_b_d  = req_exp_B[i*ES +: ES];
                k_a_d    = req_k_A[i*K_BITS +: K_BITS];
                k_b_d    = req_k_B[i*K_BITS +: K_BITS];
                sign_a_d = req_sign_A[i];
                sign_b_d = req_sign_B[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N_REQ - 1);
            gnt_q       <= '0;
            start_q     <= 1'b0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            k_a_q       <= '0;
            k_b_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_exp_q   <= '0;
            rsp_sign_q  <= 1'b0;
            rsp_nar_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
`ifdef EXP_ARB_WATCHDOG_EN
            wd_q        <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        gnt_q    <= N_REQ'(1) << pick_d;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        ptr_q    <= pick_d;
                        exp_a_q  <= exp_a_d;
                        exp_b_q  <= exp_b_d;
                        k_a_q    <= k_a_d;
                        k_b_q    <= k_b_d;
                        sign_a_q <= sign_a_d;
                        sign_b_q <= sign_b_d;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_q   <= '0;
                    start_q <= 1'b0;
`ifdef EXP_ARB_WATCHDOG_EN
                    wd_q    <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (adder_done) begin
                        state_q <= SETTLE;
`ifdef EXP_ARB_WATCHDOG_EN
                    // Expire on the WAIT cycle whose increment brings the count to TIMEOUT_CYC,
                    // so the error response appears TIMEOUT_CYC cycles after entering WAIT.
                    end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= ptr_q;
                        rsp_exp_q   <= '0;
                        rsp_sign_q  <= 1'b0;
                        rsp_nar_q   <= 1'b1;
                        rsp_zero_q  <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                SETTLE: begin
                    // Adder flags become valid one cycle after done, hence the capture here.
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= ptr_q;
                    rsp_exp_q   <= adder_exp_raw;
                    rsp_sign_q  <= adder_sign;
                    rsp_nar_q   <= adder_NaR;
                    rsp_zero_q  <= adder_zero;
`ifdef EXP_ARB_WATCHDOG_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef EXP_ARB_WATCHDOG_EN
                        if (rsp_err_q) begin
                            // The adder never finished, so there is no result to consume.
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            valid_out_q <= 1'b1;
                            state_q     <= DRAIN;
                        end
`else
                        valid_out_q <= 1'b1;
                        state_q     <= DRAIN;
`endif
                    end
                end
                DRAIN: begin
                    valid_out_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign adder_start     = start_q;
    assign adder_exp_A     = exp_a_q;
    assign adder_exp_B     = exp_b_q;
    assign adder_k_A       = k_a_q;
    assign adder_k_B       = k_b_q;
    assign adder_sign_A    = sign_a_q;
    assign adder_sign_B    = sign_b_q;
    assign adder_valid_out = valid_out_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = rsp_id_q;
    assign rsp_exp_raw     = rsp_exp_q;
    assign rsp_sign        = rsp_sign_q;
    assign rsp_NaR         = rsp_nar_q;
    assign rsp_zero        = rsp_zero_q;
    assign busy            = busy_q;
`ifdef EXP_ARB_WATCHDOG_EN
    assign rsp_err         = rsp_err_q;
`else
    assign rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_exp_adder_arbiter.sv
// tb_exp_adder_arbiter: scoreboard bench for exp_adder_arbiter with a behavioural exp_adder model
module tb_exp_adder_arbiter;

    localparam int N_REQ    = 4;
    localparam int ES       = 3;
    localparam int K_BITS   = 6;
    localparam int MAX_BITS = ES + K_BITS;
    localparam int ID_W     = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*ES-1:0]     req_exp_A = '0, req_exp_B = '0;
    logic [N_REQ*K_BITS-1:0] req_k_A = '0, req_k_B = '0;
    logic [N_REQ-1:0]        req_sign_A = '0, req_sign_B = '0;
    logic [N_REQ-1:0]        gnt;
    logic                    adder_start, adder_valid_out;
    logic [ES-1:0]           adder_exp_A, adder_exp_B;
    logic [K_BITS-1:0]       adder_k_A, adder_k_B;
    logic                    adder_sign_A, adder_sign_B;
    logic                    adder_done, adder_sign, adder_NaR, adder_zero;
    logic [MAX_BITS-1:0]     adder_exp_raw;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b1;
    logic [ID_W-1:0]         rsp_id;
    logic [MAX_BITS-1:0]     rsp_exp_raw;
    logic                    rsp_sign, rsp_NaR, rsp_zero, rsp_err, busy;

    always #5 clk = ~clk;

    exp_adder_arbiter #(.N_REQ(N_REQ), .ES(ES), .K_BITS(K_BITS), .MAX_BITS(MAX_BITS), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_exp_A(req_exp_A), .req_exp_B(req_exp_B), .req_k_A(req_k_A), .req_k_B(req_k_B),
        .req_sign_A(req_sign_A), .req_sign_B(req_sign_B),
        .gnt(gnt), .adder_start(adder_start),
        .adder_exp_A(adder_exp_A), .adder_exp_B(adder_exp_B), .adder_k_A(adder_k_A), .adder_k_B(adder_k_B),
        .adder_sign_A(adder_sign_A), .adder_sign_B(adder_sign_B), .adder_valid_out(adder_valid_out),
        .adder_done(adder_done), .adder_sign(adder_sign), .adder_NaR(adder_NaR), .adder_zero(adder_zero),
        .adder_exp_raw(adder_exp_raw),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_exp_raw(rsp_exp_raw),
        .rsp_sign(rsp_sign), .rsp_NaR(rsp_NaR), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    // Adder model: done rises 3 edges after the start edge (visible in S+4), result and
    // flags follow one cycle later; before that the outputs carry deliberately wrong values.
    logic       hang = 1'b0, force_nar = 1'b0;
    logic       m_run;
    logic [2:0] m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_cnt <= '0; adder_done <= 1'b0;
            adder_exp_raw <= '1; adder_sign <= 1'b0; adder_NaR <= 1'b0; adder_zero <= 1'b0;
        end else begin
            if (adder_start) begin
                m_run <= 1'b1; m_cnt <= 3'd1; adder_done <= 1'b0;
                adder_exp_raw <= '1; adder_sign <= ~(adder_sign_A ^ adder_sign_B);
                adder_NaR <= ~force_nar; adder_zero <= 1'b1;
            end else if (m_run) begin
                m_cnt <= m_cnt + 3'd1;
                if (m_cnt == 3'd3 && !hang) adder_done <= 1'b1;
                if (m_cnt == 3'd4 && adder_done) begin
                    adder_exp_raw <= (MAX_BITS'(adder_k_A) << ES) + MAX_BITS'(adder_exp_A)
                                   + (MAX_BITS'(adder_k_B) << ES) + MAX_BITS'(adder_exp_B);
                    adder_sign <= adder_sign_A ^ adder_sign_B;
                    adder_NaR <= force_nar; adder_zero <= 1'b0; m_run <= 1'b0;
                end
            end
            if (adder_valid_out) adder_done <= 1'b0;
        end
    end

    typedef struct { int id; int ex; int sg; int nar; int zr; int err; } rsp_t;
    rsp_t sb[$];
    rsp_t e;
    int   checks = 0, failures = 0;
    int   cyc = 0, vo_count = 0, rise_cyc = -1;
    int   gnt_cyc[$], gnt_val[$];
    logic prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: logs grants/pulses and pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (gnt != 0 || adder_start) begin
                check("start_with_gnt", int'(adder_start), int'(gnt != 0));
                gnt_cyc.push_back(cyc);
                gnt_val.push_back(int'(gnt));
            end
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            if (adder_valid_out) vo_count++;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp: got id %0d expected no response", rsp_id);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", int'(rsp_id), e.id);
                    check("rsp_exp_raw", int'(rsp_exp_raw), e.ex);
                    check("rsp_sign", int'(rsp_sign), e.sg);
                    check("rsp_NaR", int'(rsp_NaR), e.nar);
                    check("rsp_zero", int'(rsp_zero), e.zr);
                    check("rsp_err", int'(rsp_err), e.err);
                end
            end
            prev_valid = rsp_valid;
        end else prev_valid = 1'b0;
    end

    task automatic set_op(input int i, input int ka, input int ea, input int kb, input int eb,
                          input int sa, input int sbv);
        req_k_A[i*K_BITS +: K_BITS] = K_BITS'(ka);
        req_exp_A[i*ES +: ES]       = ES'(ea);
        req_k_B[i*K_BITS +: K_BITS] = K_BITS'(kb);
        req_exp_B[i*ES +: ES]       = ES'(eb);
        req_sign_A[i]               = sa[0];
        req_sign_B[i]               = sbv[0];
    endtask

    task automatic drive_req(input logic [N_REQ-1:0] v);
        @(posedge clk); #1 req = v;
    endtask

    task automatic wait_gnt(input string name, input int max);
        int n = 0;
        do begin @(negedge clk); n++; end while (gnt == 0 && n < max);
        check({name, "_gnt_seen"}, int'(gnt != 0), 1);
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < max) begin @(negedge clk); n++; end
        check({name, "_completes"}, int'(n < max), 1);
    endtask

    function automatic int last_gnt();
        return gnt_cyc.size() != 0 ? gnt_cyc[gnt_cyc.size()-1] : -1000;
    endfunction

    task automatic clear_logs();
        gnt_cyc.delete(); gnt_val.delete(); vo_count = 0; rise_cyc = -1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", int'(gnt), 0);
        check("rst_start", int'(adder_start), 0);
        check("rst_valid_out", int'(adder_valid_out), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_payload", int'({rsp_id, rsp_exp_raw, rsp_sign, rsp_NaR, rsp_zero, rsp_err}), 0);
        rst_n = 1'b1;

        // All requesters at once: 0,1,2,3,0 at 9-cycle spacing.
        set_op(0, 1, 2, 0, 1, 0, 0);
        set_op(1, 2, 3, 1, 5, 1, 0);
        set_op(2, 3, 7, 3, 7, 1, 1);
        set_op(3, 4, 0, 2, 6, 0, 1);
        sb.push_back('{0, 11, 0, 0, 0, 0});
        sb.push_back('{1, 32, 1, 0, 0, 0});
        sb.push_back('{2, 62, 0, 0, 0, 0});
        sb.push_back('{3, 54, 1, 0, 0, 0});
        sb.push_back('{0, 11, 0, 0, 0, 0});
        clear_logs();
        drive_req(4'b1111);
        n = 0;
        while (gnt_cyc.size() < 5 && n < 80) begin @(negedge clk); n++; end
        drive_req(4'b0000);
        wait_done("all", 40);
        check("all_gnt_count", gnt_val.size(), 5);
        for (int i = 0; i < gnt_val.size(); i++) check("rr_order", gnt_val[i], 1 << (i % 4));
        for (int i = 1; i < gnt_cyc.size(); i++) check("issue_spacing", gnt_cyc[i] - gnt_cyc[i-1], 9);
        check("all_valid_out_pulses", vo_count, 5);
        check("all_latency", rise_cyc - last_gnt(), 6);

        // Single request from requester 1.
        clear_logs();
        sb.push_back('{1, 32, 1, 0, 0, 0});
        drive_req(4'b0010);
        wait_gnt("single", 10);
        check("single_gnt", int'(gnt), 2);
        drive_req(4'b0000);
        @(negedge clk);
        check("gnt_one_cycle", int'(gnt), 0);
        wait_done("single", 20);
        check("single_gnt_count", gnt_cyc.size(), 1);
        check("single_latency", rise_cyc - last_gnt(), 6);
        check("single_valid_out_pulses", vo_count, 1);

        // Backpressure: 5 stalled cycles in RESP while requester 0 waits.
        clear_logs();
        sb.push_back('{2, 62, 0, 0, 0, 0});
        sb.push_back('{0, 11, 0, 0, 0, 0});
        @(posedge clk); #1 rsp_ready = 1'b0;
        drive_req(4'b0100);
        wait_gnt("bp", 10);
        check("bp_gnt", int'(gnt), 4);
        drive_req(4'b0001);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_rsp_seen", int'(rsp_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", int'(rsp_valid), 1);
            check("bp_id_stable", int'(rsp_id), 2);
            check("bp_exp_stable", int'(rsp_exp_raw), 62);
            check("bp_no_valid_out", int'(adder_valid_out), 0);
            check("bp_no_gnt", int'(gnt), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("drain_valid_out", int'(adder_valid_out), 1);
        check("drain_busy", int'(busy), 1);
        @(negedge clk);
        check("idle_gap_valid_out", int'(adder_valid_out), 0);
        check("idle_gap_busy", int'(busy), 0);
        check("idle_gap_gnt", int'(gnt), 0);
        @(negedge clk);
        check("bp_next_gnt", int'(gnt), 1);
        drive_req(4'b0000);
        wait_done("bp", 30);
        check("bp_valid_out_pulses", vo_count, 2);

        // Flag passthrough.
        force_nar = 1'b1;
        sb.push_back('{1, 32, 1, 1, 0, 0});
        drive_req(4'b0010);
        wait_gnt("nar", 10);
        drive_req(4'b0000);
        wait_done("nar", 20);
        force_nar = 1'b0;

        // Reset in WAIT aborts without a response.
        drive_req(4'b1000);
        wait_gnt("abort", 10);
        drive_req(4'b0000);
        @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_ctrl", int'({gnt, adder_start, adder_valid_out, rsp_valid}), 0);
        check("abort_operands", int'({adder_exp_A, adder_exp_B, adder_k_A, adder_k_B, adder_sign_A, adder_sign_B}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        sb.push_back('{3, 54, 1, 0, 0, 0});
        drive_req(4'b1000);
        wait_gnt("post_rst", 10);
        check("post_rst_gnt", int'(gnt), 8);
        drive_req(4'b0000);
        wait_done("post_rst", 20);
        check("post_rst_latency", rise_cyc - last_gnt(), 6);

        // Adder that never finishes.
        hang = 1'b1;
        clear_logs();
`ifdef EXP_ARB_WATCHDOG_EN
        sb.push_back('{0, 0, 0, 1, 0, 1});
`endif
        drive_req(4'b0001);
        wait_gnt("hang", 10);
        drive_req(4'b0000);
`ifdef EXP_ARB_WATCHDOG_EN
        wait_done("wd", 40);
        check("wd_latency", rise_cyc - last_gnt(), 16);
        check("wd_no_valid_out", vo_count, 0);
`else
        repeat (40) @(negedge clk);
        check("hang_busy", int'(busy), 1);
        check("hang_no_rsp", int'(rsp_valid), 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
`endif
        hang = 1'b0;
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1);
    end

endmodule
